// File: rtl/dx_sched.sv
// Sequencer for the 8-point DX transform engine: collects eight samples, clears and runs the
// engine, then streams the eight results out. Optional RUN watchdog under DX_SCHED_TIMEOUT_EN.
module dx_sched #(
  parameter int unsigned CLR_CYCLES = 2,
  parameter int unsigned TIMEOUT    = 200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  output logic [63:0] x_vec,
  output logic        dx_reset,
  output logic        dx_start,
  input  logic        dx_done,
  input  logic [95:0] y_vec,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] out_data,
  output logic [2:0]  out_idx,
  output logic        out_last,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {StFill, StClear, StRun, StDrain} state_e;

  localparam int unsigned CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
  localparam logic [CW-1:0] CLR_LAST = CW'(CLR_CYCLES - 1);

  if (CLR_CYCLES < 1 || TIMEOUT < 1) begin : g_param_check
    $error("dx_sched: CLR_CYCLES and TIMEOUT must be at least 1");
  end

  state_e        r_state, w_state_next;
  logic [2:0]    r_fill_cnt;
  logic [CW-1:0] r_clr_cnt;
  logic [2:0]    r_out_idx;
  logic [63:0]   r_x_vec;
  logic [95:0]   r_ybuf;
  logic [6:0]    w_y_base;
  logic          w_in_acc;
  logic          w_out_acc;
  logic          w_timeout;

  assign w_in_acc  = in_valid && in_ready;
  assign w_out_acc = out_valid && out_ready;

`ifdef DX_SCHED_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  logic [TW-1:0] r_to_cnt;
  logic          r_err;

  // A done on the same edge as the limit still wins.
  assign w_timeout = (r_state == StRun) && !dx_done && (r_to_cnt == TO_LAST);
  assign err       = r_err;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_to_cnt <= '0;
      r_err    <= 1'b0;
    end else begin
      if (r_state != StRun) r_to_cnt <= '0;
      else                  r_to_cnt <= r_to_cnt + TW'(1);
      if (w_timeout) r_err <= 1'b1;
    end
  end
`else
  assign w_timeout = 1'b0;
  assign err       = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= StFill;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StFill:  if (w_in_acc && r_fill_cnt == 3'd7) w_state_next = StClear;
      StClear: if (r_clr_cnt == CLR_LAST) w_state_next = StRun;
      StRun:   if (dx_done || w_timeout) w_state_next = StDrain;
      StDrain: if (w_out_acc && r_out_idx == 3'd7) w_state_next = StFill;
      default: w_state_next = StFill;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    dx_reset  = 1'b1;
    dx_start  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (r_state)
      StFill: begin
        in_ready = 1'b1;
        busy     = 1'b0;
      end
      StClear: begin
        dx_reset = 1'b1;
      end
      StRun: begin
        dx_reset = 1'b0;
        dx_start = 1'b1;
      end
      StDrain: begin
        out_valid = 1'b1;
      end
      default: begin
        busy = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fill_cnt <= 3'd0;
      r_clr_cnt  <= '0;
      r_out_idx  <= 3'd0;
      r_x_vec    <= '0;
      r_ybuf     <= '0;
    end else begin
      // Fill count wraps 7 -> 0 on the last accept.
      if (w_in_acc) begin
        r_x_vec[{r_fill_cnt, 3'b000} +: 8] <= in_data;
        r_fill_cnt                         <= r_fill_cnt + 3'd1;
      end
      if (r_state == StClear) begin
        r_clr_cnt <= (r_clr_cnt == CLR_LAST) ? '0 : r_clr_cnt + CW'(1);
      end
      if (r_state == StRun) begin
        if (dx_done)        r_ybuf <= y_vec;
        else if (w_timeout) r_ybuf <= '0;
      end
      if (w_out_acc) r_out_idx <= r_out_idx + 3'd1;
    end
  end

  assign w_y_base = {4'b0000, r_out_idx} * 7'd12;
  assign x_vec    = r_x_vec;
  assign out_idx  = r_out_idx;
  assign out_data = r_ybuf[w_y_base +: 12];
  assign out_last = (r_state == StDrain) && (r_out_idx == 3'd7);

endmodule

// File: tb/tb_dx_sched.sv
// Self-checking bench for dx_sched: table of blocks driven through an engine stub, results
// checked by a scoreboard, plus hand sequences for reset mid-RUN and the optional timeout.
module tb_dx_sched;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [63:0] x_vec;
  logic        dx_reset;
  logic        dx_start;
  logic        dx_done;
  logic [95:0] y_vec;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [11:0] out_data;
  logic [2:0]  out_idx;
  logic        out_last;
  logic        busy;
  logic        err;

  int n_chk = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0][7:0]  smp;
    logic [7:0][11:0] y;
    logic [63:0]      xexp;
    bit               gap;
    bit               bp;
    bit               stale;
    bit               overlap;
  } blk_t;

  blk_t       blk [6];
  logic [15:0] sb_q [$];

  bit   bp_mode = 1'b0;
  int   ph      = 0;
  bit   stub_en = 1'b1;
  int   stub_cnt = 0;
  logic stub_done = 1'b0;
  logic stale = 1'b0;

  always #5 clk = ~clk;

  dx_sched #(
    .CLR_CYCLES(2),
    .TIMEOUT   (50)
  ) u_dut (
    .clk      (clk),
    .reset    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .x_vec    (x_vec),
    .dx_reset (dx_reset),
    .dx_start (dx_start),
    .dx_done  (dx_done),
    .y_vec    (y_vec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last),
    .busy     (busy),
    .err      (err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Engine stub: done pulses 20 cycles after start rises.
  always @(posedge clk) begin
    if (!dx_start) begin
      stub_cnt  <= 0;
      stub_done <= 1'b0;
    end else begin
      stub_cnt  <= stub_cnt + 1;
      stub_done <= stub_en && (stub_cnt == 19);
    end
  end
  assign dx_done = stub_done | stale;

  always @(posedge clk) begin
    #1;
    if (bp_mode) begin
      out_ready = ((ph % 4) == 0) || ((ph % 4) == 3);
      ph++;
    end else begin
      out_ready = 1'b1;
    end
  end

  logic        hold;
  logic [11:0] hold_data;
  logic [2:0]  hold_idx;
  logic [15:0] e;
  always @(negedge clk) begin
    chk("reset_vs_start", dx_reset, !dx_start);
    if (!rst_n) begin
      hold = 1'b0;
    end else begin
      if (out_valid && hold) begin
        chk("hold_data", out_data, hold_data);
        chk("hold_idx", out_idx, hold_idx);
      end
      if (out_valid) chk("in_ready_in_drain", in_ready, 0);
      else           chk("last_idle", out_last, 0);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_chk++;
          n_err++;
          $display("FAIL unexpected_word: got idx %0d data %0h want none", out_idx, out_data);
        end else begin
          e = sb_q.pop_front();
          chk("out_data", out_data, e[11:0]);
          chk("out_idx", out_idx, e[14:12]);
          chk("out_last", out_last, e[15]);
        end
      end
      hold      = out_valid && !out_ready;
      hold_data = out_data;
      hold_idx  = out_idx;
    end
  end

  task automatic feed(input blk_t b, output bit ok);
    int  k = 0;
    int  guard = 0;
    bit  acc;
    ok = 1'b1;
    while (k < 8) begin
      if (b.gap && (guard % 2 == 1)) begin
        in_valid = 1'b0;
        in_data  = 8'h5A;
      end else begin
        in_valid = 1'b1;
        in_data  = b.smp[k];
      end
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) k++;
      guard++;
      if (guard > 400) begin
        ok = 1'b0;
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  // Entered 1ns after the 8th accept; leaves 1ns after the edge that starts RUN.
  task automatic clr_check(input logic [63:0] xexp);
    chk("clr_reset", dx_reset, 1);
    chk("clr_start", dx_start, 0);
    chk("clr_in_ready", in_ready, 0);
    chk("clr_busy", busy, 1);
    chk("x_vec", x_vec, xexp);
    @(posedge clk);
    #1;
    chk("clr1_start", dx_start, 0);
    chk("clr1_reset", dx_reset, 1);
    @(posedge clk);
    #1;
    chk("run_start", dx_start, 1);
    chk("run_reset", dx_reset, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sb_q.size() != 0 || busy) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_done", n < 300, 1);
    chk("idle_reset", dx_reset, 1);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_valid", out_valid, 0);
  endtask

  task automatic run_block(input blk_t b);
    bit ok;
    int n;
    bp_mode = b.bp;
    feed(b, ok);
    chk("feed_done", ok, 1);
    if (!ok) return;
    for (int k = 0; k < 8; k++) begin
      sb_q.push_back({k == 7, 3'(k), b.y[k]});
      y_vec[12*k +: 12] = b.y[k];
    end
    clr_check(b.xexp);
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("done_to_valid", n, 21);
    chk("start_fall", dx_start, 0);
    if (!out_valid) return;
    // Later captures of y_vec would show up as garbage words.
    y_vec = {8{12'hA5C}};
    if (b.stale) begin
      repeat (2) begin
        @(posedge clk);
        #1;
      end
      stale = 1'b1;
      @(posedge clk);
      #1;
      stale = 1'b0;
    end
    if (!b.overlap) wait_idle();
  endtask

  logic [7:0] gsmp [8];
  bit         ok;
  int         n;

  initial begin
    #200us;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1);
  end

  initial begin
    gsmp = '{8'h80, 8'h7F, 8'h00, 8'hFF, 8'h40, 8'hC0, 8'h05, 8'hFB};
    for (int i = 0; i < 6; i++) begin
      blk[i].gap     = 1'b0;
      blk[i].bp      = 1'b0;
      blk[i].stale   = 1'b0;
      blk[i].overlap = 1'b0;
    end
    for (int k = 0; k < 8; k++) begin
      blk[0].smp[k] = 8'(k + 1);
      blk[0].y[k]   = 12'(10 * k - 35);
      blk[1].smp[k] = 8'(8'h11 * (k + 1));
      blk[1].y[k]   = 12'(585 * k - 2048);
      blk[2].smp[k] = gsmp[k];
      blk[2].y[k]   = 12'(-1 - 300 * k);
      blk[3].smp[k] = 8'(8'h10 + k);
      blk[3].y[k]   = 12'(111 * k);
      blk[4].smp[k] = 8'(8'hF0 + k);
      blk[4].y[k]   = 12'(2047 - 3 * k);
      blk[5].smp[k] = (k % 2 == 1) ? 8'hAA : 8'h55;
      blk[5].y[k]   = (k % 2 == 1) ? 12'h800 : 12'h7FF;
    end
    blk[0].xexp = 64'h0807060504030201;
    blk[1].xexp = 64'h8877665544332211;
    blk[2].xexp = 64'hFB05C040FF007F80;
    blk[3].xexp = 64'h1716151413121110;
    blk[4].xexp = 64'hF7F6F5F4F3F2F1F0;
    blk[5].xexp = 64'hAA55AA55AA55AA55;
    blk[1].bp      = 1'b1;
    blk[2].gap     = 1'b1;
    blk[3].stale   = 1'b1;
    blk[4].stale   = 1'b1;
    blk[5].stale   = 1'b1;
    blk[3].overlap = 1'b1;
    blk[4].overlap = 1'b1;

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    y_vec    = '0;
    #23;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_dx_reset", dx_reset, 1);
    chk("rst_dx_start", dx_start, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_x_vec", x_vec, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_data", out_data, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 6; i++) run_block(blk[i]);

    // Reset five cycles into RUN drops the block.
    bp_mode = 1'b0;
    feed(blk[1], ok);
    chk("feed_rst_blk", ok, 1);
    n = 0;
    while (!dx_start && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_start", dx_start, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_start", dx_start, 0);
    chk("mid_rst_reset", dx_reset, 1);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_x_vec", x_vec, 0);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    run_block(blk[0]);

`ifdef DX_SCHED_TIMEOUT_EN
    stub_en = 1'b0;
    bp_mode = 1'b0;
    feed(blk[3], ok);
    chk("feed_to_blk", ok, 1);
    for (int k = 0; k < 8; k++) sb_q.push_back({k == 7, 3'(k), 12'h000});
    y_vec = {8{12'h3C3}};
    clr_check(blk[3].xexp);
    repeat (49) begin
      @(posedge clk);
      #1;
    end
    chk("to49_err", err, 0);
    chk("to49_start", dx_start, 1);
    @(posedge clk);
    #1;
    chk("to50_err", err, 1);
    chk("to50_start", dx_start, 0);
    chk("to50_valid", out_valid, 1);
    wait_idle();
    stub_en = 1'b1;
    run_block(blk[0]);
    chk("err_sticky", err, 1);
`else
    chk("err_tied", err, 0);
`endif

    chk("sb_empty", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
